dm_read_arbiter: RTL and testbench
==================================

// Module: dm_read_arbiter
// PURPOSE
//  Shares one DataMover MM2S (read) channel among NUM_REQ traffic generators/clients.
//  - Round-robin arbitration of 72-bit read commands; the TAG field is rewritten with the requester index.
//  - Read data is steered back in command order.
//  - Read status is routed to the requester by its tag.
//  Sits between the stream_tg-style clients and the DataMover read command, data and status ports.
// PARAMETERS
//  NUM_REQ          4   requester count, 1..16 (limited by the 4-bit TAG)
//  DATA_WIDTH       64  read data width
//  KEEP_WIDTH       8   DATA_WIDTH/8
//  MAX_OUTSTANDING  8   in-order ID FIFO depth; power of 2, >=2
// PORTS
//  aclk            in   1                clock
//  aresetn         in   1                reset
//  req_cmd         in   NUM_REQ*72       per-requester read cmd, slice i = [72*i+:72]
//  req_cmd_valid   in   NUM_REQ          cmd valid
//  req_cmd_ready   out  NUM_REQ          cmd accepted
//  m_cmd           out  72               to DataMover read cmd
//  m_cmd_valid     out  1
//  m_cmd_ready     in   1
//  s_data          in   DATA_WIDTH       from DataMover read data
//  s_data_keep     in   KEEP_WIDTH
//  s_data_last     in   1
//  s_data_valid    in   1
//  s_data_ready    out  1
//  rsp_data        out  DATA_WIDTH       broadcast to all requesters
//  rsp_data_keep   out  KEEP_WIDTH       broadcast
//  rsp_data_last   out  1                broadcast
//  rsp_data_valid  out  NUM_REQ          one-hot per requester
//  rsp_data_ready  in   NUM_REQ
//  s_sts           in   8                DataMover read status: [3:0] tag, [7] okay
//  s_sts_valid     in   1
//  s_sts_ready     out  1
//  rsp_sts         out  8                broadcast, passed unmodified
//  rsp_sts_valid   out  NUM_REQ
//  rsp_sts_ready   in   NUM_REQ
//  sts_error       out  1                sticky: status seen with tag >= NUM_REQ
// BEHAVIOUR
//  - Reset: aresetn, synchronous, active-low; clock aclk.
//    - m_cmd=0, m_cmd_valid=0, sts_error=0.
//    - ID FIFO empty; RR pointer=0.
//    - Consequently all req_cmd_ready, rsp_*_valid and s_data_ready are 0.
//  - Command register: m_cmd/m_cmd_valid are registered. The slot is "free" when !m_cmd_valid | m_cmd_ready.
//  - Grant condition: slot free & FIFO count < MAX_OUTSTANDING & any req_cmd_valid.
//    - The winner g is the first valid index at or after rr_ptr, searched cyclically.
//  - On grant, in the same cycle:
//    - req_cmd_ready[g]=1 (combinational; all other requesters 0).
//    - m_cmd <= req_cmd[g] with bits [67:64] replaced by g[3:0]; all other fields are untouched.
//    - m_cmd_valid <= 1.
//    - Push g into the ID FIFO.
//    - rr_ptr <= (g+1) mod NUM_REQ.
//  - Command latency: req valid -> m_cmd_valid is 1 cycle.
//  - Throughput: 1 cmd/cycle while m_cmd_ready=1.
//  - Slot free with no grant: m_cmd_valid <= 0.
//  - m_cmd stays stable while m_cmd_valid & !m_cmd_ready.
//  - FIFO full blocks grants even if a pop occurs in the same cycle. A simultaneous push and pop when not full is legal.
//  - Data path (0-cycle, combinational), h = FIFO head:
//    - rsp_data_valid[h] = s_data_valid & !empty.
//    - s_data_ready = !empty & rsp_data_ready[h].
//    - Empty FIFO: s_data_ready=0 and all rsp_data_valid=0.
//    - Pop on s_data_valid & s_data_ready & s_data_last.
//    - Beats after pop go to the next head; no bubble is required.
//  - Status path (0-cycle), t = s_sts[3:0]:
//    - t < NUM_REQ: rsp_sts_valid[t] = s_sts_valid and s_sts_ready = rsp_sts_ready[t].
//    - t >= NUM_REQ: s_sts_ready=1, no rsp_sts_valid, sts_error <= 1 on the handshake.
//    - Status is independent of the ID FIFO.
//  - FIFO pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.
//  - Reset mid-operation:
//    - Outstanding IDs and any held command are discarded.
//    - The DataMover must be reset in the same cycle; the block does not track its in-flight transfers.
//  - NUM_REQ=1: arbitration degenerates to pass-through with TAG forced to 0.
// STRUCTURE
//  - Shared package dm_pkg holds:
//    - DM_CMD_W=72.
//    - Command field slices: BTT[22:0], TYPE[23], DSA[29:24], EOF[30], DRR[31], SADDR[63:32], TAG[67:64], RSVD[71:68].
//    - Status fields: STS_TAG[3:0], STS_OKAY=7.
//  - Sub-module dm_id_fifo: synchronous FIFO of clog2(NUM_REQ)-bit IDs.
//    - Ports: push, pop, din, head, empty, full, count.
//    - Registered pointers; head is read combinationally.
//  - Round-robin search, command register and steering muxes live in the top module.
// TESTING
//  1. Reset: aresetn=0 for 3 cycles with all inputs active
//     -> m_cmd_valid=0, all req_cmd_ready=0, s_data_ready=0, sts_error=0.
//  2. Req0 and req2 valid together, m_cmd_ready=1, rr_ptr=0
//     -> grant 0 (m_cmd[67:64]=0), then grant 2 (tag=2) the next cycle; SADDR/BTT bit-exact.
//  3. All 4 requesters hold valid continuously
//     -> grant order 0,1,2,3,0 with tags matching; m_cmd_ready low 5 cycles -> m_cmd stable, no ready to any requester.
//  4. Issue cmds from req1 then req3; DataMover returns 2 beats (last on 2nd) then 1 beat
//     -> beats 1-2 to rsp_data_valid[1], beat 3 to [3].
//     Then drop rsp_data_ready[1] for 4 cycles -> s_data_ready=0 with no beat lost.
//  5. Issue 8 cmds with no data returned -> 9th request is not granted until one last-beat pop occurs.
//  6. s_sts=8'h82 -> rsp_sts_valid[2]=1 and rsp_sts=8'h82;
//     s_sts=8'h8F with NUM_REQ=4 -> accepted, sts_error=1 and stays 1 until reset.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared DataMover definitions.
// Holds the 72-bit MM2S command layout, the status byte field positions and a helper that
// rewrites the command tag. Imported by dm_read_arbiter and dm_id_fifo users.
package dm_pkg;

  localparam int unsigned DM_CMD_W = 72;
  localparam int unsigned DM_STS_W = 8;

  // Status byte fields.
  localparam int unsigned STS_TAG_LSB = 0;
  localparam int unsigned STS_TAG_MSB = 3;
  localparam int unsigned STS_OKAY    = 7;

  // Command layout, MSB first: RSVD[71:68] TAG[67:64] SADDR[63:32] DRR[31] EOF[30]
  // DSA[29:24] TYPE[23] BTT[22:0].
  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        cmd_type;
    logic [22:0] btt;
  } dm_cmd_t;

  // Replace only the TAG field; every other bit of the command passes through.
  function automatic logic [DM_CMD_W-1:0] dm_set_tag(input logic [DM_CMD_W-1:0] cmd,
                                                     input logic [3:0]          tag);
    dm_cmd_t c;
    c     = dm_cmd_t'(cmd);
    c.tag = tag;
    return DM_CMD_W'(c);
  endfunction

endpackage

// File: rtl/dm_id_fifo.sv
// In-order requester ID FIFO.
// Records which requester owns each outstanding read so returned data can be steered in
// command order. Registered pointers, combinational head read.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   push, din      enqueue an ID (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   head           current oldest ID
//   empty, full    occupancy flags
//   count          number of stored IDs, 0..Depth
module dm_id_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned IdW   = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            push,
  input  logic            pop,
  input  logic [IdW-1:0]  din,
  output logic [IdW-1:0]  head,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] count
);

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read meaningfully.
  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dm_read_arbiter.sv
// Shares one DataMover MM2S read channel among NUM_REQ clients.
// Commands are arbitrated round-robin and re-tagged with the winner index; read data is
// steered back in command order using an ID FIFO; status is routed by its tag.
// Ports:
//   aclk, aresetn                  clock, synchronous active-low reset
//   req_cmd/_valid/_ready          per-requester 72-bit commands, slice i = [72*i +: 72]
//   m_cmd/_valid/_ready            registered command to the DataMover
//   s_data/_keep/_last/_valid/_ready  read data from the DataMover
//   rsp_data/_keep/_last           read data broadcast to all requesters
//   rsp_data_valid/_ready          per-requester data handshake
//   s_sts/_valid/_ready            DataMover read status ([3:0] tag)
//   rsp_sts, rsp_sts_valid/_ready  status broadcast, per-requester handshake
//   sts_error                      sticky: status seen with an out-of-range tag
module dm_read_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned KEEP_WIDTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ*DM_CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]          req_cmd_valid,
  output logic [NUM_REQ-1:0]          req_cmd_ready,
  output logic [DM_CMD_W-1:0]         m_cmd,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic [KEEP_WIDTH-1:0]       s_data_keep,
  input  logic                        s_data_last,
  input  logic                        s_data_valid,
  output logic                        s_data_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [KEEP_WIDTH-1:0]       rsp_data_keep,
  output logic                        rsp_data_last,
  output logic [NUM_REQ-1:0]          rsp_data_valid,
  input  logic [NUM_REQ-1:0]          rsp_data_ready,
  input  logic [DM_STS_W-1:0]         s_sts,
  input  logic                        s_sts_valid,
  output logic                        s_sts_ready,
  output logic [DM_STS_W-1:0]         rsp_sts,
  output logic [NUM_REQ-1:0]          rsp_sts_valid,
  input  logic [NUM_REQ-1:0]          rsp_sts_ready,
  output logic                        sts_error
);

  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic [DM_CMD_W-1:0] m_cmd_q;
  logic                m_cmd_valid_q;
  logic [IdW-1:0]      rr_ptr_q;
  logic [IdW-1:0]      rr_ptr_d;
  logic                sts_error_q;

  logic                slot_free;
  logic                grant;
  logic                found_hi;
  logic                found_lo;
  logic [IdW-1:0]      idx_hi;
  logic [IdW-1:0]      idx_lo;
  logic [IdW-1:0]      grant_idx;
  logic [DM_CMD_W-1:0] sel_cmd;
  logic [DM_CMD_W-1:0] tagged_cmd;

  logic                fifo_pop;
  logic [IdW-1:0]      fifo_head;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CntW-1:0]     fifo_count;
  logic                unused_fifo_count;

  logic [3:0]          sts_tag;
  logic                sts_tag_ok;

  // ---------------------------------------------------------------------------
  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall.
  // ---------------------------------------------------------------------------
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_cmd_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = IdW'(i);
        if (32'(rr_ptr_q) <= 32'(i)) begin
          found_hi = 1'b1;
          idx_hi   = IdW'(i);
        end
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
  end

  assign slot_free = !m_cmd_valid_q || m_cmd_ready;
  // Full blocks a grant even when a pop lands in the same cycle. Reset also blocks so no
  // requester sees ready while the block is held in reset.
  assign grant     = aresetn && slot_free && !fifo_full && found_lo;
  assign rr_ptr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IdW'(1);

  always_comb begin
    req_cmd_ready = '0;
    sel_cmd       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IdW'(i)) begin
        req_cmd_ready[i] = grant;
        sel_cmd          = req_cmd[DM_CMD_W*i +: DM_CMD_W];
      end
    end
  end

  assign tagged_cmd = dm_set_tag(sel_cmd, 4'(grant_idx));

  // ---------------------------------------------------------------------------
  // Command register, RR pointer and sticky status error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_cmd_q       <= '0;
      m_cmd_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
      sts_error_q   <= 1'b0;
    end else begin
      if (grant) begin
        m_cmd_q       <= tagged_cmd;
        m_cmd_valid_q <= 1'b1;
        rr_ptr_q      <= rr_ptr_d;
      end else if (slot_free) begin
        m_cmd_valid_q <= 1'b0;
      end
      // Bad-tag status is always accepted, so valid alone is the handshake.
      if (s_sts_valid && !sts_tag_ok) sts_error_q <= 1'b1;
    end
  end

  assign m_cmd       = m_cmd_q;
  assign m_cmd_valid = m_cmd_valid_q;
  assign sts_error   = sts_error_q;

  // ---------------------------------------------------------------------------
  // Outstanding-ID FIFO and in-order data steering.
  // ---------------------------------------------------------------------------
  assign fifo_pop = s_data_valid && s_data_ready && s_data_last;

  dm_id_fifo #(
    .Depth (MAX_OUTSTANDING),
    .IdW   (IdW)
  ) u_id_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (grant),
    .pop     (fifo_pop),
    .din     (grant_idx),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Occupancy is tracked through the full flag; the count is only observable state.
  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    rsp_data_valid = '0;
    s_data_ready   = 1'b0;
    if (!fifo_empty) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (fifo_head == IdW'(i)) begin
          rsp_data_valid[i] = s_data_valid;
          s_data_ready      = rsp_data_ready[i];
        end
      end
    end
  end

  assign rsp_data      = s_data;
  assign rsp_data_keep = s_data_keep;
  assign rsp_data_last = s_data_last;

  // ---------------------------------------------------------------------------
  // Status routing by tag, independent of the ID FIFO.
  // ---------------------------------------------------------------------------
  assign sts_tag    = s_sts[STS_TAG_MSB:STS_TAG_LSB];
  assign sts_tag_ok = (32'(sts_tag) < NUM_REQ);

  always_comb begin
    rsp_sts_valid = '0;
    s_sts_ready   = !sts_tag_ok;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sts_tag_ok && (sts_tag == 4'(i))) begin
        rsp_sts_valid[i] = s_sts_valid;
        s_sts_ready      = rsp_sts_ready[i];
      end
    end
  end

  assign rsp_sts = s_sts;

endmodule

// File: tb/tb_dm_read_arbiter.sv
module tb_dm_read_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MO = 8;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [NR*72-1:0] req_cmd;
  logic [NR-1:0]  req_cmd_valid;
  logic [NR-1:0]  req_cmd_ready;
  logic [71:0]    m_cmd;
  logic           m_cmd_valid;
  logic           m_cmd_ready;
  logic [DW-1:0]  s_data;
  logic [KW-1:0]  s_data_keep;
  logic           s_data_last;
  logic           s_data_valid;
  logic           s_data_ready;
  logic [DW-1:0]  rsp_data;
  logic [KW-1:0]  rsp_data_keep;
  logic           rsp_data_last;
  logic [NR-1:0]  rsp_data_valid;
  logic [NR-1:0]  rsp_data_ready;
  logic [7:0]     s_sts;
  logic           s_sts_valid;
  logic           s_sts_ready;
  logic [7:0]     rsp_sts;
  logic [NR-1:0]  rsp_sts_valid;
  logic [NR-1:0]  rsp_sts_ready;
  logic           sts_error;

  always #5 aclk = ~aclk;

  dm_read_arbiter #(
    .NUM_REQ         (NR),
    .DATA_WIDTH      (DW),
    .KEEP_WIDTH      (KW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .req_cmd        (req_cmd),
    .req_cmd_valid  (req_cmd_valid),
    .req_cmd_ready  (req_cmd_ready),
    .m_cmd          (m_cmd),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .s_data         (s_data),
    .s_data_keep    (s_data_keep),
    .s_data_last    (s_data_last),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .rsp_data       (rsp_data),
    .rsp_data_keep  (rsp_data_keep),
    .rsp_data_last  (rsp_data_last),
    .rsp_data_valid (rsp_data_valid),
    .rsp_data_ready (rsp_data_ready),
    .s_sts          (s_sts),
    .s_sts_valid    (s_sts_valid),
    .s_sts_ready    (s_sts_ready),
    .rsp_sts        (rsp_sts),
    .rsp_sts_valid  (rsp_sts_valid),
    .rsp_sts_ready  (rsp_sts_ready),
    .sts_error      (sts_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: queue of owners of outstanding reads, cyclic RR pointer.
  logic [71:0]   exp_m_cmd   = '0;
  logic          exp_m_valid = 1'b0;
  int            exp_rr      = 0;
  int            idq[$];
  logic          exp_sts_err = 1'b0;
  logic          exp_grant   = 1'b0;
  int            exp_win     = -1;
  logic [NR-1:0] exp_req_ready;
  logic [NR-1:0] exp_rsp_data_valid;
  logic [NR-1:0] exp_rsp_sts_valid;
  logic          exp_s_data_ready;
  logic          exp_s_sts_ready;

  task automatic model_comb();
    int   t;
    logic free;
    free    = !exp_m_valid || m_cmd_ready;
    exp_win = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (exp_rr + k) % NR;
      if (exp_win < 0 && req_cmd_valid[idx]) exp_win = idx;
    end
    exp_grant     = aresetn && free && (idq.size() < MO) && (exp_win >= 0);
    exp_req_ready = exp_grant ? (NR'(1) << exp_win) : '0;
    if (idq.size() == 0) begin
      exp_rsp_data_valid = '0;
      exp_s_data_ready   = 1'b0;
    end else begin
      exp_rsp_data_valid = s_data_valid ? (NR'(1) << idq[0]) : '0;
      exp_s_data_ready   = rsp_data_ready[idq[0]];
    end
    t = int'(s_sts[3:0]);
    if (t < NR) begin
      exp_rsp_sts_valid = s_sts_valid ? (NR'(1) << t) : '0;
      exp_s_sts_ready   = rsp_sts_ready[t];
    end else begin
      exp_rsp_sts_valid = '0;
      exp_s_sts_ready   = 1'b1;
    end
  endtask

  task automatic model_clk();
    logic        do_pop;
    logic [71:0] c;
    if (!aresetn) begin
      exp_m_cmd   = '0;
      exp_m_valid = 1'b0;
      exp_rr      = 0;
      idq.delete();
      exp_sts_err = 1'b0;
    end else begin
      do_pop = s_data_valid && exp_s_data_ready && s_data_last;
      if (exp_grant) begin
        c           = req_cmd[72*exp_win +: 72];
        c[67:64]    = 4'(exp_win);
        exp_m_cmd   = c;
        exp_m_valid = 1'b1;
        exp_rr      = (exp_win + 1) % NR;
      end else if (!exp_m_valid || m_cmd_ready) begin
        exp_m_valid = 1'b0;
      end
      if (do_pop) void'(idq.pop_front());
      if (exp_grant) idq.push_back(exp_win);
      if (s_sts_valid && int'(s_sts[3:0]) >= NR) exp_sts_err = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_comb();
    model_clk();
    #1;
  endtask

  task automatic set_idle();
    req_cmd_valid  = '0;
    m_cmd_ready    = 1'b0;
    s_data         = '0;
    s_data_keep    = '0;
    s_data_last    = 1'b0;
    s_data_valid   = 1'b0;
    rsp_data_ready = '0;
    s_sts          = '0;
    s_sts_valid    = 1'b0;
    rsp_sts_ready  = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    set_idle();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn        = 1'b0;
    for (int i = 0; i < NR; i++) req_cmd[72*i +: 72] = 72'({$urandom(), $urandom(), $urandom()});
    req_cmd_valid  = '1;
    m_cmd_ready    = 1'b1;
    s_data_valid   = 1'b1;
    s_data_last    = 1'b1;
    rsp_data_ready = '1;
    s_sts          = 8'h8F;
    s_sts_valid    = 1'b1;
    rsp_sts_ready  = '1;
    repeat (3) tick();
    n_checks++;
    if (m_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_m_cmd_valid: got %b expected 0", m_cmd_valid);
    end
    n_checks++;
    if (m_cmd !== 72'h0) begin
      n_fail++; $display("FAIL reset_m_cmd: got %h expected 0", m_cmd);
    end
    n_checks++;
    if (req_cmd_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_cmd_ready: got %b expected 0000", req_cmd_ready);
    end
    n_checks++;
    if (s_data_ready !== 1'b0 || rsp_data_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_data: got ready=%b valid=%b expected 0/0000", s_data_ready,
               rsp_data_valid);
    end
    n_checks++;
    if (sts_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_sts_error: got %b expected 0", sts_error);
    end
    set_idle();
    aresetn = 1'b1;
  endtask

  task automatic test_two_req();
    do_reset();
    @(negedge aclk);
    req_cmd[0*72 +: 72] = 72'h3F_1234_5678_80_00_0100;
    req_cmd[2*72 +: 72] = 72'hA7_CAFE_F00D_C0_00_2000;
    req_cmd_valid       = 4'b0101;
    m_cmd_ready         = 1'b1;
    #1;
    n_checks++;
    if (req_cmd_ready !== 4'b0001) begin
      n_fail++; $display("FAIL two_req_grant0: got %b expected 0001", req_cmd_ready);
    end
    tick();
    n_checks++;
    if (m_cmd_valid !== 1'b1 || m_cmd !== 72'h30_1234_5678_80_00_0100) begin
      n_fail++;
      $display("FAIL two_req_cmd0: got v=%b %h expected v=1 301234567880000100", m_cmd_valid,
               m_cmd);
    end
    @(negedge aclk);
    req_cmd_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_cmd_ready !== 4'b0100) begin
      n_fail++; $display("FAIL two_req_grant2: got %b expected 0100", req_cmd_ready);
    end
    tick();
    n_checks++;
    if (m_cmd_valid !== 1'b1 || m_cmd !== 72'hA2_CAFE_F00D_C0_00_2000) begin
      n_fail++;
      $display("FAIL two_req_cmd2: got v=%b %h expected v=1 A2CAFEF00DC0002000", m_cmd_valid,
               m_cmd);
    end
    @(negedge aclk);
    req_cmd_valid = '0;
    tick();
    n_checks++;
    if (m_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL two_req_idle: got m_cmd_valid=%b expected 0", m_cmd_valid);
    end
  endtask

  task automatic test_rr_all();
    logic [71:0] c0;
    logic [71:0] held;
    do_reset();
    @(negedge aclk);
    for (int i = 0; i < NR; i++) req_cmd[72*i +: 72] = 72'({$urandom(), $urandom(), $urandom()});
    c0            = req_cmd[0 +: 72];
    req_cmd_valid = '1;
    m_cmd_ready   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [71:0] e;
      if (k > 0) @(negedge aclk);
      #1;
      n_checks++;
      if (req_cmd_ready !== (4'b0001 << (k % NR))) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %b expected %b", k, req_cmd_ready,
                 4'b0001 << (k % NR));
      end
      e        = req_cmd[72*(k % NR) +: 72];
      e[67:64] = 4'(k % NR);
      tick();
      n_checks++;
      if (m_cmd_valid !== 1'b1 || m_cmd !== e) begin
        n_fail++;
        $display("FAIL rr_cmd_%0d: got v=%b %h expected v=1 %h", k, m_cmd_valid, m_cmd, e);
      end
    end
    held        = c0;
    held[67:64] = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      m_cmd_ready = 1'b0;
      for (int i = 0; i < NR; i++) req_cmd[72*i +: 72] = 72'({$urandom(), $urandom(), $urandom()});
      #1;
      n_checks++;
      if (req_cmd_ready !== 4'b0000) begin
        n_fail++; $display("FAIL rr_stall_ready_%0d: got %b expected 0000", k, req_cmd_ready);
      end
      tick();
      n_checks++;
      if (m_cmd_valid !== 1'b1 || m_cmd !== held) begin
        n_fail++;
        $display("FAIL rr_stall_cmd_%0d: got v=%b %h expected v=1 %h", k, m_cmd_valid, m_cmd,
                 held);
      end
    end
  endtask

  task automatic test_data_steer();
    logic [DW-1:0] beat2;
    int            got1;
    got1 = 0;
    do_reset();
    @(negedge aclk);
    req_cmd_valid  = 4'b0010;
    m_cmd_ready    = 1'b1;
    rsp_data_ready = '1;
    tick();
    @(negedge aclk);
    req_cmd_valid = 4'b1000;
    tick();
    @(negedge aclk);
    req_cmd_valid = '0;
    s_data        = 64'({$urandom(), $urandom()});
    s_data_keep   = 8'hFF;
    s_data_last   = 1'b0;
    s_data_valid  = 1'b1;
    #1;
    n_checks++;
    if (rsp_data_valid !== 4'b0010 || s_data_ready !== 1'b1 || rsp_data !== s_data) begin
      n_fail++;
      $display("FAIL steer_beat1: got valid=%b ready=%b data=%h expected 0010/1/%h",
               rsp_data_valid, s_data_ready, rsp_data, s_data);
    end
    if (rsp_data_valid[1] && s_data_ready) got1++;
    tick();
    @(negedge aclk);
    beat2          = 64'({$urandom(), $urandom()});
    s_data         = beat2;
    s_data_last    = 1'b1;
    rsp_data_ready = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge aclk);
      #1;
      n_checks++;
      if (s_data_ready !== 1'b0 || rsp_data_valid !== 4'b0010) begin
        n_fail++;
        $display("FAIL steer_backpressure_%0d: got ready=%b valid=%b expected 0/0010", k,
                 s_data_ready, rsp_data_valid);
      end
      tick();
    end
    @(negedge aclk);
    rsp_data_ready = '1;
    #1;
    n_checks++;
    if (s_data_ready !== 1'b1 || rsp_data_valid !== 4'b0010 || rsp_data !== beat2) begin
      n_fail++;
      $display("FAIL steer_beat2: got ready=%b valid=%b data=%h expected 1/0010/%h",
               s_data_ready, rsp_data_valid, rsp_data, beat2);
    end
    if (rsp_data_valid[1] && s_data_ready) got1++;
    tick();
    n_checks++;
    if (got1 !== 2) begin
      n_fail++; $display("FAIL steer_req1_beats: got %0d expected 2", got1);
    end
    @(negedge aclk);
    s_data = 64'({$urandom(), $urandom()});
    #1;
    n_checks++;
    if (rsp_data_valid !== 4'b1000 || s_data_ready !== 1'b1 || rsp_data_last !== 1'b1) begin
      n_fail++;
      $display("FAIL steer_beat3: got valid=%b ready=%b last=%b expected 1000/1/1",
               rsp_data_valid, s_data_ready, rsp_data_last);
    end
    tick();
    @(negedge aclk);
    #1;
    n_checks++;
    if (rsp_data_valid !== 4'b0000 || s_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_empty: got valid=%b ready=%b expected 0000/0", rsp_data_valid,
               s_data_ready);
    end
    s_data_valid = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    do_reset();
    @(negedge aclk);
    req_cmd_valid  = 4'b0001;
    m_cmd_ready    = 1'b1;
    rsp_data_ready = '1;
    for (int k = 0; k < MO + 3; k++) begin
      if (k > 0) @(negedge aclk);
      #1;
      n_checks++;
      if (req_cmd_ready !== ((k < MO) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL full_grant_%0d: got %b expected %b", k, req_cmd_ready,
                 (k < MO) ? 4'b0001 : 4'b0000);
      end
      tick();
    end
    @(negedge aclk);
    s_data_valid = 1'b1;
    s_data_last  = 1'b1;
    #1;
    n_checks++;
    if (req_cmd_ready !== 4'b0000 || s_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_cycle: got cmd_ready=%b data_ready=%b expected 0000/1",
               req_cmd_ready, s_data_ready);
    end
    tick();
    @(negedge aclk);
    s_data_valid = 1'b0;
    #1;
    n_checks++;
    if (req_cmd_ready !== 4'b0001) begin
      n_fail++; $display("FAIL full_after_pop: got %b expected 0001", req_cmd_ready);
    end
    tick();
    @(negedge aclk);
    req_cmd_valid = '0;
    tick();
  endtask

  task automatic test_status();
    do_reset();
    @(negedge aclk);
    s_sts         = 8'h82;
    s_sts_valid   = 1'b1;
    rsp_sts_ready = 4'b0100;
    #1;
    n_checks++;
    if (rsp_sts_valid !== 4'b0100 || rsp_sts !== 8'h82 || s_sts_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sts_tag2: got valid=%b sts=%h ready=%b expected 0100/82/1", rsp_sts_valid,
               rsp_sts, s_sts_ready);
    end
    rsp_sts_ready = 4'b1011;
    #1;
    n_checks++;
    if (s_sts_ready !== 1'b0) begin
      n_fail++; $display("FAIL sts_tag2_backpressure: got %b expected 0", s_sts_ready);
    end
    tick();
    @(negedge aclk);
    s_sts         = 8'h8F;
    rsp_sts_ready = '0;
    #1;
    n_checks++;
    if (s_sts_ready !== 1'b1 || rsp_sts_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL sts_bad_tag: got ready=%b valid=%b expected 1/0000", s_sts_ready,
               rsp_sts_valid);
    end
    tick();
    n_checks++;
    if (sts_error !== 1'b1) begin
      n_fail++; $display("FAIL sts_error_set: got %b expected 1", sts_error);
    end
    @(negedge aclk);
    s_sts_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (sts_error !== 1'b1) begin
      n_fail++; $display("FAIL sts_error_sticky: got %b expected 1", sts_error);
    end
    do_reset();
    n_checks++;
    if (sts_error !== 1'b0) begin
      n_fail++; $display("FAIL sts_error_reset: got %b expected 0", sts_error);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge aclk);
      aresetn = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < NR; i++) req_cmd[72*i +: 72] = 72'({$urandom(), $urandom(), $urandom()});
      req_cmd_valid  = 4'($urandom());
      m_cmd_ready    = ($urandom_range(0, 3) != 0);
      s_data         = 64'({$urandom(), $urandom()});
      s_data_keep    = 8'($urandom());
      s_data_last    = ($urandom_range(0, 2) == 0);
      s_data_valid   = ($urandom_range(0, 2) == 0);
      rsp_data_ready = 4'($urandom());
      s_sts          = {1'($urandom()), 3'b000, 4'($urandom_range(0, 5))};
      s_sts_valid    = ($urandom_range(0, 3) == 0);
      rsp_sts_ready  = 4'($urandom());
      #1;
      model_comb();
      n_checks++;
      if (req_cmd_ready !== exp_req_ready) begin
        n_fail++;
        $display("FAIL rnd_req_ready@%0d: got %b expected %b", cyc, req_cmd_ready,
                 exp_req_ready);
      end
      n_checks++;
      if (rsp_data_valid !== exp_rsp_data_valid || s_data_ready !== exp_s_data_ready) begin
        n_fail++;
        $display("FAIL rnd_data@%0d: got valid=%b ready=%b expected %b/%b", cyc,
                 rsp_data_valid, s_data_ready, exp_rsp_data_valid, exp_s_data_ready);
      end
      n_checks++;
      if (rsp_data !== s_data || rsp_data_keep !== s_data_keep ||
          rsp_data_last !== s_data_last) begin
        n_fail++;
        $display("FAIL rnd_data_bcast@%0d: got %h/%h/%b expected %h/%h/%b", cyc, rsp_data,
                 rsp_data_keep, rsp_data_last, s_data, s_data_keep, s_data_last);
      end
      n_checks++;
      if (rsp_sts_valid !== exp_rsp_sts_valid || s_sts_ready !== exp_s_sts_ready ||
          rsp_sts !== s_sts) begin
        n_fail++;
        $display("FAIL rnd_sts@%0d: got valid=%b ready=%b sts=%h expected %b/%b/%h", cyc,
                 rsp_sts_valid, s_sts_ready, rsp_sts, exp_rsp_sts_valid, exp_s_sts_ready, s_sts);
      end
      tick();
      n_checks++;
      if (m_cmd_valid !== exp_m_valid || m_cmd !== exp_m_cmd) begin
        n_fail++;
        $display("FAIL rnd_m_cmd@%0d: got v=%b %h expected v=%b %h", cyc, m_cmd_valid, m_cmd,
                 exp_m_valid, exp_m_cmd);
      end
      n_checks++;
      if (sts_error !== exp_sts_err) begin
        n_fail++;
        $display("FAIL rnd_sts_error@%0d: got %b expected %b", cyc, sts_error, exp_sts_err);
      end
    end
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    req_cmd = '0;
    set_idle();
    test_reset();
    test_two_req();
    test_rr_all();
    test_data_steer();
    test_fifo_full();
    test_status();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
